multicycle_controller: RTL and testbench

Control FSM for the multicycle RV32I core: sequences the shared ALU, unified instruction/data memory, instruction register, PC and register file over several cycles per instruction. It sits beside the datapath, the same way the main decoder sits beside the single-cycle datapath. It supports lw, sw, R-type, I-type ALU, beq and jal, and adds a memory-ready handshake so fetch and data accesses can stall on slow memory.

---
 rtl/riscv_ctrl_pkg.sv | 131 +++++++++++++
 rtl/imm_src_decoder.sv | 27 ++
 rtl/multicycle_controller.sv | 107 ++++++++++
 tb/tb_multicycle_controller.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
// Module   : riscv_ctrl_pkg
// Purpose  : Shared state, opcode and mux-select encodings for the multicycle
//            RV32I controller, plus the per-state Moore output table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_RTYPE  = 7'd51;
    localparam logic [6:0] OP_ITYPE  = 7'd19;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef struct packed {
        logic        adr_src;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        pc_update;
        logic        fetch;
        result_src_e result_src;
        alu_src_a_e  alu_src_a;
        alu_src_b_e  alu_src_b;
        alu_op_e     alu_op;
    } ctrl_t;

    // Moore outputs of each state; FETCH enables are qualified by mem_ready later
    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.fetch      = 1'b1;
                c.result_src = RES_ALURESULT;
                c.alu_src_b  = SRCB_FOUR;
            end
            DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            MEMREAD:  c.adr_src = 1'b1;
            MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_op    = ALUOP_FUNCT;
            end
            EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: c.reg_write = 1'b1;
            BEQ: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_src_decoder.sv
// ============================================================================
// Module   : imm_src_decoder
// Purpose  : Combinational opcode to immediate-format select; unknown -> I.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_src_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Multicycle RV32I control FSM with memory-ready stalls.
//            Optional ILLEGAL_TRAP_EN macro routes unknown opcodes to TRAP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUop,
    output logic [1:0]         ImmSrc,
    output logic               RegWrite,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    state_e r_state;
    state_e w_next;
    ctrl_t  r_ctrl;

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:    w_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next = MEMADR;
                    OP_RTYPE:          w_next = EXECR;
                    OP_ITYPE:          w_next = EXECI;
                    OP_BRANCH:         w_next = BEQ;
                    OP_JAL:            w_next = JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:           w_next = TRAP;
`else
                    default:           w_next = FETCH;
`endif
                endcase
            end
            MEMADR:   w_next = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  w_next = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: w_next = mem_ready ? FETCH : MEMWRITE;
            MEMWB:    w_next = FETCH;
            EXECR:    w_next = ALUWB;
            EXECI:    w_next = ALUWB;
            JAL:      w_next = ALUWB;
            ALUWB:    w_next = FETCH;
            BEQ:      w_next = FETCH;
`ifdef ILLEGAL_TRAP_EN
            TRAP:     w_next = TRAP;
`endif
            default:  w_next = FETCH;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_ctrl  <= state_ctrl(FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= state_ctrl(w_next);
        end
    end

    assign PCWrite   = ~reset & (r_ctrl.pc_update | (r_ctrl.fetch & mem_ready)
                                 | (r_ctrl.branch & zero));
    assign IRWrite   = ~reset & r_ctrl.fetch & mem_ready;
    assign MemWrite  = ~reset & r_ctrl.mem_write;
    assign RegWrite  = ~reset & r_ctrl.reg_write;
    assign AdrSrc    = r_ctrl.adr_src;
    assign ResultSrc = r_ctrl.result_src;
    assign ALUSrcA   = r_ctrl.alu_src_a;
    assign ALUSrcB   = r_ctrl.alu_src_b;
    assign ALUop     = r_ctrl.alu_op;
    assign state     = reset ? '0 : STATE_W'(r_state);

`ifdef ILLEGAL_TRAP_EN
    assign illegal = ~reset & (r_state == TRAP);
`else
    assign illegal = 1'b0;
`endif

    imm_src_decoder u_imm_src_decoder (
        .op      (op),
        .imm_src (ImmSrc)
    );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Directed scoreboard bench for multicycle_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUop, ImmSrc;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        chk_state;
        logic [3:0]  st;
        logic [15:0] vec;
        logic [15:0] mask;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    multicycle_controller #(.STATE_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUop     (ALUop),
        .ImmSrc    (ImmSrc),
        .RegWrite  (RegWrite),
        .illegal   (illegal),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Expected outputs for a state, taken directly from the output table
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic [6:0] o,
                                             input logic z, input logic mr, input logic rst);
        logic       pcw, adr, mw, ir, rw, ill;
        logic [1:0] rs, a, b, aop, imm;
        {pcw, adr, mw, ir, rw, ill} = '0;
        {rs, a, b, aop, imm} = '0;
        case (o)
            7'd35:   imm = 2'b01;
            7'd99:   imm = 2'b10;
            7'd111:  imm = 2'b11;
            default: imm = 2'b00;
        endcase
        case (st)
            4'd0:  begin pcw = mr; ir = mr; rs = 2'b10; b = 2'b10; end
            4'd1:  begin a = 2'b01; b = 2'b01; end
            4'd2:  begin a = 2'b10; b = 2'b01; end
            4'd3:  adr = 1'b1;
            4'd4:  begin rs = 2'b01; rw = 1'b1; end
            4'd5:  begin adr = 1'b1; mw = 1'b1; end
            4'd6:  begin a = 2'b10; aop = 2'b10; end
            4'd7:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            4'd8:  rw = 1'b1;
            4'd9:  begin a = 2'b10; aop = 2'b01; pcw = z; end
            4'd10: begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
            4'd11: ill = 1'b1;
            default: ;
        endcase
        if (rst) {pcw, mw, ir, rw, ill} = '0;
        return {pcw, adr, mw, ir, rs, a, b, aop, imm, rw, ill};
    endfunction

    task automatic step(input string nm, input logic rst, input logic [6:0] o,
                        input logic z, input logic mr, input logic [3:0] st,
                        input logic chk);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        op        = o;
        zero      = z;
        mem_ready = mr;
        e.chk_state = chk;
        e.st        = st;
        e.vec       = exp_ctrl(st, o, z, mr, rst);
        // During reset only the enables and illegal are defined
        e.mask      = rst ? 16'hB003 : 16'hFFFF;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic run(input string nm, input logic [6:0] o, input logic z,
                       input logic [31:0] seq, input int n, input logic [15:0] mrb);
        for (int i = 0; i < n; i++)
            step(nm, 1'b0, o, z, mrb[i], seq[4*i +: 4], 1'b1);
    endtask

    // Monitor: samples late in the low phase, away from the rising edge
    initial begin
        exp_t        e;
        string       nm;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                       ALUSrcB, ALUop, ImmSrc, RegWrite, illegal};
                if (e.chk_state) begin
                    checks++;
                    if (state !== e.st) begin
                        errors++;
                        $display("FAIL %s state: got %0d want %0d", nm, state, e.st);
                    end
                end
                checks++;
                if ((act & e.mask) !== (e.vec & e.mask)) begin
                    errors++;
                    $display("FAIL %s ctrl (state %0d): got %b want %b mask %b",
                             nm, e.st, act, e.vec, e.mask);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; op = 7'd0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reach EXECR, then hold reset there for two cycles
        step("start_fetch", 1'b0, 7'd51, 1'b0, 1'b1, 4'd0, 1'b1);
        step("start_decode", 1'b0, 7'd51, 1'b0, 1'b1, 4'd1, 1'b1);
        step("reset_in_execr", 1'b1, 7'd51, 1'b0, 1'b1, 4'd6, 1'b0);
        step("reset_hold", 1'b1, 7'd51, 1'b0, 1'b1, 4'd0, 1'b1);

        run("lw", 7'd3, 1'b0, 32'h0004_3210, 5, 16'h001F);
        run("sw_stall", 7'd35, 1'b0, 32'h0555_5210, 7, 16'h0047);
        run("rtype_fetch_stall", 7'd51, 1'b0, 32'h0086_1000, 6, 16'h003C);
        run("itype_ready_ignored", 7'd19, 1'b0, 32'h0000_8710, 4, 16'h0009);
        run("beq_taken", 7'd99, 1'b1, 32'h0000_0910, 3, 16'h0007);
        run("beq_not_taken", 7'd99, 1'b0, 32'h0000_0910, 3, 16'h0007);
        run("jal", 7'd111, 1'b0, 32'h0000_8A10, 4, 16'h000F);

`ifdef ILLEGAL_TRAP_EN
        run("illegal_trap", 7'h7F, 1'b0, 32'h000B_BB10, 5, 16'h001F);
        step("trap_reset", 1'b1, 7'h7F, 1'b0, 1'b1, 4'd11, 1'b0);
        step("trap_reset_hold", 1'b1, 7'h7F, 1'b0, 1'b1, 4'd0, 1'b1);
        step("after_trap", 1'b0, 7'd3, 1'b0, 1'b1, 4'd0, 1'b1);
`else
        run("illegal_nop", 7'h7F, 1'b0, 32'h0000_0010, 2, 16'h0003);
        step("after_nop", 1'b0, 7'd3, 1'b0, 1'b1, 4'd0, 1'b1);
`endif

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #5;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
